bcd_code_converter_seq: RTL and testbench

BCD_CODE_CONVERTER_SEQ -- requirements
Module: bcd_code_converter_seq

---
 rtl/bcd_code_converter_seq.sv | 77 +++++++
 tb/tb_bcd_code_converter_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bcd_code_converter_seq.sv
// bcd_code_converter_seq: converts a multi-digit word one 4-bit digit per clock (Excess-3, 2421, Gray)
module bcd_code_converter_seq #(
    parameter int N_DIGITS = 4
) (
    input  logic                  clk_pin,
    input  logic                  rst_pin,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [4*N_DIGITS-1:0] din,
    output logic [4*N_DIGITS-1:0] dout,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [N_DIGITS-1:0]   err_mask
);
    localparam int W  = 4 * N_DIGITS;
    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    typedef enum logic {IDLE, CONV} state_t;
    state_t              state, state_nxt;
    logic [IW-1:0]       idx;
    logic [W-1:0]        din_sh, work, work_nxt;
    logic [1:0]          mode_sh;
    logic [N_DIGITS-1:0] mask, mask_nxt;
    logic [3:0]          d, q;
    logic                valid, last;
    always_comb begin
        d = din_sh[4*int'(idx) +: 4];
        valid = mode_sh == 2'd1 ? (d >= 4'd3 && d <= 4'd12) : (d <= 4'd9);
        q = !valid          ? 4'hF :
            mode_sh == 2'd0 ? d + 4'd3 :
            mode_sh == 2'd1 ? d - 4'd3 :
            mode_sh == 2'd2 ? (d <= 4'd4 ? d : d + 4'd6) :
                              d ^ (d >> 1);
        work_nxt = work;
        work_nxt[4*int'(idx) +: 4] = q;
        mask_nxt = mask;
        mask_nxt[idx] = !valid;
        last = idx == IW'(N_DIGITS - 1);
        state_nxt = state == IDLE ? (start ? CONV : IDLE) : (last ? IDLE : CONV);
    end
    always_ff @(posedge clk_pin) begin
        if (rst_pin) state <= IDLE;
        else state <= state_nxt;
    end
    // The final edge publishes work_nxt so the last digit lands without an extra cycle.
    always_ff @(posedge clk_pin) begin
        if (rst_pin) begin
            idx      <= '0;
            din_sh   <= '0;
            mode_sh  <= '0;
            work     <= '0;
            mask     <= '0;
            dout     <= '0;
            err_mask <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                din_sh  <= din;
                mode_sh <= mode;
                idx     <= '0;
            end else if (state == CONV) begin
                work <= work_nxt;
                mask <= mask_nxt;
                idx  <= idx + 1'b1;
                if (last) begin
                    dout     <= work_nxt;
                    err_mask <= mask_nxt;
                    err      <= |mask_nxt;
                    done     <= 1'b1;
                end
            end
        end
    end
    assign busy = state == CONV;
endmodule

// File: tb/tb_bcd_code_converter_seq.sv
// tb_bcd_code_converter_seq: directed scoreboard bench for bcd_code_converter_seq with N_DIGITS=4
module tb_bcd_code_converter_seq;
    localparam int N = 4;
    typedef struct {
        logic [15:0] dout;
        logic [3:0]  mask;
    } exp_t;
    logic        clk_pin = 1'b0;
    logic        rst_pin = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] din = 16'h0;
    logic [15:0] dout;
    logic        busy, done, err;
    logic [3:0]  err_mask;
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    bcd_code_converter_seq #(.N_DIGITS(N)) dut (
        .clk_pin(clk_pin), .rst_pin(rst_pin), .start(start), .mode(mode), .din(din),
        .dout(dout), .busy(busy), .done(done), .err(err), .err_mask(err_mask)
    );
    always #5 clk_pin = ~clk_pin;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [4:0] ref_digit(input logic [1:0] m, input logic [3:0] v);
        logic [3:0] gray [10] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC, 4'hD};
        logic [3:0] c2421 [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        case (m)
            2'd0: return v < 10 ? {1'b0, 4'(v + 3)} : 5'h1F;
            2'd1: return (v >= 3 && v <= 12) ? {1'b0, 4'(v - 3)} : 5'h1F;
            2'd2: return v < 10 ? {1'b0, c2421[v]} : 5'h1F;
            default: return v < 10 ? {1'b0, gray[v]} : 5'h1F;
        endcase
    endfunction
    function automatic exp_t model(input logic [1:0] m, input logic [15:0] w);
        exp_t e;
        logic [4:0] r;
        for (int i = 0; i < N; i++) begin
            r = ref_digit(m, w[4*i +: 4]);
            e.dout[4*i +: 4] = r[3:0];
            e.mask[i] = r[4];
        end
        return e;
    endfunction
    task automatic tick();
        @(posedge clk_pin);
        #1;
    endtask
    task automatic wait_done_and_check(input string tag);
        int   nb = 0;
        int   cyc = 0;
        exp_t e;
        while (!done && cyc < 20) begin
            if (busy) nb++;
            tick();
            cyc++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_cycles"}, nb, N);
        chk({tag, "_busy_at_done"}, busy, 0);
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_dout"}, dout, e.dout);
            chk({tag, "_err_mask"}, err_mask, e.mask);
            chk({tag, "_err"}, err, |e.mask);
        end
    endtask
    task automatic convert(input string tag, input logic [1:0] m, input logic [15:0] w);
        start = 1'b1;
        mode = m;
        din = w;
        sb.push_back(model(m, w));
        tick();
        start = 1'b0;
        mode = ~m;
        din = ~w;
        wait_done_and_check(tag);
    endtask
    initial begin
        logic [15:0] seq_w [4] = '{16'h1234, 16'h5678, 16'h9A90, 16'h0000};
        logic [15:0] held;
        int          ndone;
        exp_t        ex;
        start = 1'b1;
        din = 16'h9051;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dout", dout, 0);
        chk("rst_err", err, 0);
        chk("rst_mask", err_mask, 0);
        rst_pin = 1'b0;
        start = 1'b0;
        tick();
        chk("rst_no_capture", busy, 0);
        ex = model(2'd0, 16'h9051);
        chk("model_sanity_9051", ex.dout, 16'hC384);
        convert("m0_9051", 2'd0, 16'h9051);
        held = dout;
        tick();
        chk("done_single_cycle", done, 0);
        tick();
        chk("dout_hold", dout, held);
        convert("m1_C384", 2'd1, 16'hC384);
        convert("m2_9573", 2'd2, 16'h9573);
        convert("m3_9876", 2'd3, 16'h9876);
        convert("m0_12A4", 2'd0, 16'h12A4);
        convert("m1_0D3F", 2'd1, 16'h0D3F);
        convert("m2_FA50", 2'd2, 16'hFA50);
        convert("m3_0FA2", 2'd3, 16'h0FA2);
        for (int i = 0; i < 4; i++) convert("rand", 2'($urandom_range(3)), 16'($urandom));
        start = 1'b1;
        mode = 2'd0;
        din = seq_w[0];
        sb.push_back(model(2'd0, seq_w[0]));
        tick();
        for (int i = 1; i < 4; i++) begin
            din = seq_w[i];
            wait_done_and_check("b2b");
            chk("b2b_idle_in_done", busy, 0);
            if (i == 3) start = 1'b0;
            else sb.push_back(model(2'd0, seq_w[i]));
            tick();
            chk("b2b_restart_busy", busy, i != 3);
            din = ~seq_w[i];
        end
        chk("b2b_scoreboard_drained", sb.size(), 0);
        convert("pre_abort", 2'd3, 16'h4321);
        start = 1'b1;
        mode = 2'd0;
        din = 16'h1111;
        tick();
        start = 1'b0;
        tick();
        rst_pin = 1'b1;
        tick();
        rst_pin = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_dout", dout, 0);
        chk("abort_err", err, 0);
        chk("abort_mask", err_mask, 0);
        ndone = 0;
        for (int i = 0; i < N + 3; i++) begin
            if (done || busy) ndone++;
            tick();
        end
        chk("abort_quiet", ndone, 0);
        chk("abort_dout_held_zero", dout, 0);
        convert("post_abort", 2'd0, 16'h9051);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
